// File: rtl/dmem_if.sv
// CPU data-port bundle between the MEM stage (master) and the memory responder (slave).
interface dmem_if;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_en,
    output mem_wen,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_wen,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-port responder: byte-lane data RAM with one-cycle registered reads plus a small
// MMIO window (LED, switch sample, free-running cycle counter, scratch).
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        bus_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  // Source of the word currently shown on mem_rdata; NONE/ZERO both read as 0.
  localparam logic [1:0] RSEL_NONE = 2'd0;
  localparam logic [1:0] RSEL_RAM  = 2'd1;
  localparam logic [1:0] RSEL_MMIO = 2'd2;
  localparam logic [1:0] RSEL_ZERO = 2'd3;

  localparam logic [1:0] OFF_LED     = 2'd0;
  localparam logic [1:0] OFF_SW      = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  logic                  req_valid;
  logic                  is_write;
  logic                  is_read;
  logic                  ram_hit;
  logic                  mmio_hit;
  logic [1:0]            mmio_off;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           lane_mask;
  logic                  ram_wr;
  logic                  ram_rd;
  logic [31:0]           ram_q;

  logic [15:0] led_reg,     led_next;
  logic [15:0] sw_reg;
  logic [31:0] counter_reg, counter_next;
  logic [31:0] scratch_reg, scratch_next;
  logic [31:0] mmio_q_reg,  mmio_q_next;
  logic [1:0]  rsel_reg,    rsel_next;
  logic        bus_err_reg, bus_err_next;
  logic [31:0] mmio_rd_data;
  logic [31:0] rdata_mux;

  // Requests seen while reset is high are dropped entirely.
  assign req_valid = bus.mem_en && !rst;
  assign is_write  = req_valid && (bus.mem_wen != 4'b0000);
  assign is_read   = req_valid && (bus.mem_wen == 4'b0000);

  assign ram_hit  = (bus.mem_addr[31:DEPTH_LOG2+2] == '0);
  assign mmio_hit = (bus.mem_addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off = bus.mem_addr[3:2];
  assign word_idx = bus.mem_addr[DEPTH_LOG2+1:2];

  assign ram_wr = is_write && ram_hit;
  assign ram_rd = is_read && ram_hit;

  // One narrow RAM per byte lane so each lane enable maps onto its own write port.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_array [0:DEPTH-1];
      logic [7:0] q_reg;

      assign lane_mask[8*gi +: 8] = {8{bus.mem_wen[gi]}};

      always_ff @(posedge clk) begin
        if (ram_wr && bus.mem_wen[gi]) begin
          mem_array[word_idx] <= bus.mem_wdata[8*gi +: 8];
        end
        if (ram_rd) begin
          q_reg <= mem_array[word_idx];
        end
      end

      assign ram_q[8*gi +: 8] = q_reg;
    end
  endgenerate

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
    lane_merge = (old_val & ~mask) | (new_val & mask);
  endfunction

  always_comb begin
    mmio_rd_data = 32'h0;
    case (mmio_off)
      OFF_LED:     mmio_rd_data = {16'h0, led_reg};
      OFF_SW:      mmio_rd_data = {16'h0, sw_reg};
      OFF_CYCLE:   mmio_rd_data = counter_reg;
      OFF_SCRATCH: mmio_rd_data = scratch_reg;
      default:     mmio_rd_data = 32'h0;
    endcase
  end

  always_comb begin
    led_next     = led_reg;
    counter_next = counter_reg + 32'd1;
    scratch_next = scratch_reg;
    if (is_write && mmio_hit) begin
      case (mmio_off)
        OFF_LED:     led_next     = lane_merge({16'h0, led_reg}, bus.mem_wdata, lane_mask) >> 0;
        OFF_CYCLE:   counter_next = lane_merge(counter_reg, bus.mem_wdata, lane_mask);
        OFF_SCRATCH: scratch_next = lane_merge(scratch_reg, bus.mem_wdata, lane_mask);
        default:     ;
      endcase
    end
  end

  // Read target is latched at the request edge; data is presented the following cycle.
  always_comb begin
    rsel_next   = rsel_reg;
    mmio_q_next = mmio_q_reg;
    if (is_read) begin
      if (ram_hit) begin
        rsel_next = RSEL_RAM;
      end else if (mmio_hit) begin
        rsel_next   = RSEL_MMIO;
        mmio_q_next = mmio_rd_data;
      end else begin
        rsel_next = RSEL_ZERO;
      end
    end
  end

  assign bus_err_next = req_valid && !ram_hit && !mmio_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg     <= 16'h0;
      sw_reg      <= 16'h0;
      counter_reg <= 32'h0;
      scratch_reg <= 32'h0;
      mmio_q_reg  <= 32'h0;
      rsel_reg    <= RSEL_NONE;
      bus_err_reg <= 1'b0;
    end else begin
      led_reg     <= led_next;
      sw_reg      <= sw;
      counter_reg <= counter_next;
      scratch_reg <= scratch_next;
      mmio_q_reg  <= mmio_q_next;
      rsel_reg    <= rsel_next;
      bus_err_reg <= bus_err_next;
    end
  end

  always_comb begin
    rdata_mux = 32'h0;
    case (rsel_reg)
      RSEL_RAM:  rdata_mux = ram_q;
      RSEL_MMIO: rdata_mux = mmio_q_reg;
      default:   rdata_mux = 32'h0;
    endcase
  end

  assign bus.mem_rdata = rdata_mux;
  assign led           = led_reg;
  assign bus_err       = bus_err_reg;

endmodule
